l2_arbiter: RTL and testbench

Shares the single L2 video cache port among `NCORES` private L1 video caches and enforces write coherence. It grants one L1 miss/refill or write-through at a time in round-robin order and forwards it to L2. After every write it broadcasts an invalidation of the written line to all other L1s, and completes the writer's transaction only once every other L1 has acknowledged. It sits between the per-core L1 caches' L2 interfaces and the L2 cache.

---
 rtl/l2_arbiter_pkg.sv | 31 +++
 rtl/l2_arbiter_if.sv | 43 ++++
 rtl/l2_arbiter_rr_picker.sv | 33 +++
 rtl/l2_arbiter.sv | 128 ++++++++++++
 tb/tb_l2_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 arbiter slice: frame-buffer address/word types,
// default core count, grant index type, FSM state enum and the latched
// request payload.
package l2_arbiter_pkg;

  localparam int unsigned FB_ADDR_W    = 16;
  localparam int unsigned FB_WORD_W    = 32;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_WORD_W-1:0] fb_word_t;

  localparam int unsigned L2ARB_NCORES = 4;
  localparam int unsigned L2ARB_IDX_W  = $clog2(L2ARB_NCORES);

  typedef logic [L2ARB_IDX_W-1:0] arb_idx_t;

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_access = 2'd1,
    s_inval  = 2'd2,
    s_done   = 2'd3
  } arb_state_t;

  // Request captured from the granted L1 at grant time
  typedef struct packed {
    logic     w;
    fb_addr_t addr;
    fb_word_t data;
  } arb_req_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// L1/L2 side bundle of the L2 arbiter.
//   req_en/req_w/req_addr/req_in : per-L1 request (into arbiter)
//   req_out/req_ready            : shared read data, one-hot completion
//   inv/inv_addr/inv_ack         : per-L1 invalidate handshake
//   l2_en/l2_w/l2_addr/l2_in     : L2 access (out of arbiter)
//   l2_out/l2_ready              : L2 read data and completion
interface l2_arbiter_if
  import l2_arbiter_pkg::*;
#(
  parameter int unsigned NCORES = L2ARB_NCORES
);

  logic     [NCORES-1:0] req_en;
  logic     [NCORES-1:0] req_w;
  fb_addr_t [NCORES-1:0] req_addr;
  fb_word_t [NCORES-1:0] req_in;
  fb_word_t              req_out;
  logic     [NCORES-1:0] req_ready;

  logic     [NCORES-1:0] inv;
  fb_addr_t              inv_addr;
  logic     [NCORES-1:0] inv_ack;

  logic                  l2_en;
  logic                  l2_w;
  fb_addr_t              l2_addr;
  fb_word_t              l2_in;
  fb_word_t              l2_out;
  logic                  l2_ready;

  // Arbiter side
  modport slave (
    input  req_en, req_w, req_addr, req_in, inv_ack, l2_out, l2_ready,
    output req_out, req_ready, inv, inv_addr, l2_en, l2_w, l2_addr, l2_in
  );

  // L1 caches + L2 side
  modport master (
    output req_en, req_w, req_addr, req_in, inv_ack, l2_out, l2_ready,
    input  req_out, req_ready, inv, inv_addr, l2_en, l2_w, l2_addr, l2_in
  );

endinterface

// File: rtl/l2_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first set bit of req_i at or
// after ptr_i+1 (modulo N). Reusable by any shared port.
//   req_i : request vector
//   ptr_i : index of the last served requester
//   gnt_o : selected index (0 when any_o is low)
//   any_o : at least one request present
module l2_arbiter_rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);

  logic [IW-1:0] idx;

  // Scan ptr+1 .. ptr+N; first hit wins
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        gnt_o = idx;
      end
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 video cache port among NCORES L1 caches in round-robin order
// and, after every write, invalidates the line in all other L1s before
// completing the writer's transaction.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : L1 request / invalidate / L2 access bundle (slave side)
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int unsigned NCORES = L2ARB_NCORES
) (
  input  logic            clk,
  input  logic            rst_n,
  l2_arbiter_if.slave     bus_io
);

  localparam int unsigned IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  arb_req_t          req_q, req_d;
  fb_word_t          rdata_q, rdata_d;
  logic [NCORES-1:0] ack_q, ack_d;
  logic [NCORES-1:0] gnt_oh;
  logic [IDX_W-1:0]  pick;
  logic              pick_any;

  l2_arbiter_rr_picker #(
    .N (NCORES)
  ) u_picker (
    .req_i (bus_io.req_en),
    .ptr_i (ptr_q),
    .gnt_o (pick),
    .any_o (pick_any)
  );

  assign gnt_oh = NCORES'(1) << gnt_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= s_idle;
      ptr_q   <= IDX_W'(NCORES - 1);
      gnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // Next state and outputs; outputs decode from state so reset clears them at once
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    gnt_d            = gnt_q;
    req_d            = req_q;
    rdata_d          = rdata_q;
    ack_d            = ack_q;

    bus_io.req_out   = rdata_q;
    bus_io.req_ready = '0;
    bus_io.inv       = '0;
    bus_io.inv_addr  = '0;
    bus_io.l2_en     = 1'b0;
    bus_io.l2_w      = 1'b0;
    bus_io.l2_addr   = '0;
    bus_io.l2_in     = '0;

    unique case (state_q)
      s_idle: begin
        if (pick_any) begin
          gnt_d   = pick;
          req_d   = '{w:    bus_io.req_w[pick],
                      addr: bus_io.req_addr[pick],
                      data: bus_io.req_in[pick]};
          state_d = s_access;
        end
      end

      s_access: begin
        bus_io.l2_en   = 1'b1;
        bus_io.l2_w    = req_q.w;
        bus_io.l2_addr = req_q.addr;
        bus_io.l2_in   = req_q.data;
        // L2 completion wins over a same-cycle withdrawal
        if (bus_io.l2_ready) begin
          bus_io.req_out = bus_io.l2_out;
          rdata_d        = bus_io.l2_out;
          if (!req_q.w) begin
            bus_io.req_ready = gnt_oh;
            ptr_d            = gnt_q;
            state_d          = s_idle;
          end else begin
            ack_d   = gnt_oh;
            state_d = s_inval;
          end
        end else if (!bus_io.req_en[gnt_q]) begin
          state_d = s_idle;
        end
      end

      s_inval: begin
        bus_io.inv      = ~ack_q;
        bus_io.inv_addr = req_q.addr;
        ack_d           = ack_q | bus_io.inv_ack;
        if (&ack_d) begin
          state_d = s_done;
        end
      end

      s_done: begin
        bus_io.req_ready = gnt_oh;
        ptr_d            = gnt_q;
        state_d          = s_idle;
      end

      default: state_d = s_idle;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed sequences, a round-robin
// grant-order table, and randomized traffic against a transaction model.
module tb_l2_arbiter;
  import l2_arbiter_pkg::*;

  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] ack_mask;

  always #5 clk = ~clk;

  l2_arbiter_if #(.NCORES(NC)) bus ();

  // L1 acks are combinational from inv, gated per core by the bench
  assign bus.inv_ack = bus.inv & ack_mask;

  l2_arbiter #(.NCORES(NC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req_en   = '0;
    bus.req_w    = '0;
    bus.req_addr = '0;
    bus.req_in   = '0;
    bus.l2_ready = 1'b0;
    bus.l2_out   = '0;
    ack_mask     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Round-robin reference: first requester after 'last', modulo NC
  function automatic int rr_pick(input int last, input logic [NC-1:0] req);
    for (int k = 1; k <= int'(NC); k++) begin
      if (req[(last + k) % int'(NC)]) return (last + k) % int'(NC);
    end
    return -1;
  endfunction

  // Hold all cores in mask (reads) until served; record completion order
  task automatic serve(input logic [NC-1:0] mask, output logic [15:0] ord, output int cnt);
    logic [NC-1:0] pend;
    int budget;
    pend   = mask;
    budget = 0;
    ord    = '0;
    cnt    = 0;
    for (int i = 0; i < int'(NC); i++) begin
      bus.req_w[i]    = 1'b0;
      bus.req_addr[i] = 16'(16'h0100 * i);
      bus.req_in[i]   = 32'(i);
    end
    bus.req_en = pend;
    while (pend != '0 && budget < 100) begin
      bus.l2_ready = bus.l2_en;
      bus.l2_out   = $urandom;
      #1;
      if (bus.req_ready != '0) begin
        chk("tbl_req_out", 64'(bus.req_out), 64'(bus.l2_out));
        for (int i = 0; i < int'(NC); i++) begin
          if (bus.req_ready[i]) begin
            if (cnt < 4) ord = ord | (16'(i) << (4 * cnt));
            cnt++;
            pend[i] = 1'b0;
          end
        end
      end
      @(negedge clk);
      bus.req_en = pend;
      budget++;
    end
    bus.l2_ready = 1'b0;
    if (pend != '0) chk("tbl_timeout_pending", 64'(pend), 64'(0));
  endtask

  typedef struct {
    logic [NC-1:0] mask;
    logic [15:0]   ord;
    int            n;
  } vec_t;

  vec_t vecs [8];

  // Random-phase model state
  logic [NC-1:0] pend, seen_rdy, m_acked, onehot, e_inv, e_rdy;
  int            m_ptr, m_owner, lat;
  logic          m_busy, m_l2done, m_fin, m_w, e_l2en;
  fb_addr_t      m_addr;
  fb_word_t      m_data, m_rdata, e_out;
  logic [1:0]    own_ix;
  logic [15:0]   got_ord;
  int            got_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();

    // ---- Read from core 0, L2 answers in the 3rd access cycle
    do_reset();
    chk("rst_outputs", 64'({bus.l2_en, bus.l2_w, bus.req_ready, bus.inv}), 64'(0));
    chk("rst_req_out", 64'(bus.req_out), 64'(0));
    bus.req_en = 4'b0001;
    bus.req_addr[0] = 16'h0010;
    #1 chk("rd_idle_l2en", 64'(bus.l2_en), 64'(0));
    @(negedge clk); #1;
    chk("rd_l2en_rise", 64'(bus.l2_en), 64'(1));
    chk("rd_l2addr", 64'(bus.l2_addr), 64'(16'h0010));
    @(negedge clk); #1;
    chk("rd_inv_quiet", 64'(bus.inv), 64'(0));
    chk("rd_no_early_rdy", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    bus.l2_ready = 1'b1;
    bus.l2_out   = 32'hA5A5_A5A5;
    #1;
    chk("rd_req_ready", 64'(bus.req_ready), 64'(4'b0001));
    chk("rd_req_out", 64'(bus.req_out), 64'(32'hA5A5_A5A5));
    chk("rd_inv_zero", 64'(bus.inv), 64'(0));
    @(negedge clk);
    bus.l2_ready = 1'b0;
    bus.req_en   = '0;
    bus.l2_out   = 32'h1234_5678;
    #1;
    chk("rd_l2en_fall", 64'(bus.l2_en), 64'(0));
    chk("rd_req_out_hold", 64'(bus.req_out), 64'(32'hA5A5_A5A5));
    chk("rd_rdy_pulse", 64'(bus.req_ready), 64'(0));

    // ---- Grant-order table, applied from reset
    vecs[0] = '{mask: 4'b1111, ord: 16'h3210, n: 4};
    vecs[1] = '{mask: 4'b1010, ord: 16'h0031, n: 2};
    vecs[2] = '{mask: 4'b0101, ord: 16'h0020, n: 2};
    vecs[3] = '{mask: 4'b1001, ord: 16'h0003, n: 2};
    vecs[4] = '{mask: 4'b0110, ord: 16'h0021, n: 2};
    vecs[5] = '{mask: 4'b1101, ord: 16'h0203, n: 3};
    vecs[6] = '{mask: 4'b0100, ord: 16'h0002, n: 1};
    vecs[7] = '{mask: 4'b1011, ord: 16'h0103, n: 3};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      serve(vecs[v].mask, got_ord, got_cnt);
      chk($sformatf("tbl%0d_order", v), 64'(got_ord), 64'(vecs[v].ord));
      chk($sformatf("tbl%0d_count", v), 64'(got_cnt), 64'(vecs[v].n));
    end

    // ---- Core 2 writes 0x123; cores 0,1 ack at once, core 3 four cycles later
    do_reset();
    bus.req_en      = 4'b0100;
    bus.req_w[2]    = 1'b1;
    bus.req_addr[2] = 16'h0123;
    bus.req_in[2]   = 32'hCAFE_F00D;
    @(negedge clk);
    bus.l2_ready = 1'b1;
    #1;
    chk("wr_l2en", 64'(bus.l2_en), 64'(1));
    chk("wr_l2w", 64'(bus.l2_w), 64'(1));
    chk("wr_l2addr", 64'(bus.l2_addr), 64'(16'h0123));
    chk("wr_l2in", 64'(bus.l2_in), 64'(32'hCAFE_F00D));
    chk("wr_no_rdy_at_l2", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    bus.l2_ready = 1'b0;
    ack_mask     = 4'b0011;
    #1;
    chk("wr_inv_first", 64'(bus.inv), 64'(4'b1011));
    chk("wr_inv_addr", 64'(bus.inv_addr), 64'(16'h0123));
    chk("wr_l2en_drop", 64'(bus.l2_en), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("wr_inv_wait%0d", c), 64'(bus.inv), 64'(4'b1000));
      chk($sformatf("wr_rdy_wait%0d", c), 64'(bus.req_ready), 64'(0));
    end
    @(negedge clk);
    ack_mask = 4'b1011;
    #1;
    chk("wr_inv_core3_ack", 64'(bus.inv), 64'(4'b1000));
    chk("wr_rdy_not_yet", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    ack_mask = '0;
    #1;
    chk("wr_req_ready", 64'(bus.req_ready), 64'(4'b0100));
    chk("wr_inv_clear", 64'(bus.inv), 64'(0));
    @(negedge clk);
    bus.req_en = '0;
    #1 chk("wr_rdy_one_cycle", 64'(bus.req_ready), 64'(0));

    // ---- Abort: core 1 withdraws a write; ptr must stay on core 0
    do_reset();
    bus.req_en      = 4'b0001;
    bus.req_addr[0] = 16'h0040;
    @(negedge clk);
    bus.l2_ready = 1'b1;
    #1 chk("ab_core0_rdy", 64'(bus.req_ready), 64'(4'b0001));
    @(negedge clk);
    bus.l2_ready    = 1'b0;
    bus.req_en      = 4'b0010;
    bus.req_w[1]    = 1'b1;
    bus.req_addr[1] = 16'h0222;
    @(negedge clk); #1;
    chk("ab_l2addr", 64'(bus.l2_addr), 64'(16'h0222));
    @(negedge clk);
    bus.req_en = '0;
    #1 chk("ab_l2en_still", 64'(bus.l2_en), 64'(1));
    @(negedge clk); #1;
    chk("ab_l2en_fall", 64'(bus.l2_en), 64'(0));
    chk("ab_no_rdy_inv", 64'({bus.req_ready, bus.inv}), 64'(0));
    @(negedge clk);
    bus.req_en      = 4'b0110;
    bus.req_addr[2] = 16'h0333;
    @(negedge clk); #1;
    chk("ab_core1_wins", 64'(bus.l2_addr), 64'(16'h0222));

    // ---- Asynchronous reset while invalidating
    do_reset();
    bus.req_en      = 4'b0100;
    bus.req_w[2]    = 1'b1;
    bus.req_addr[2] = 16'h0456;
    bus.req_in[2]   = 32'h0BAD_0BAD;
    @(negedge clk);
    bus.l2_ready = 1'b1;
    bus.l2_out   = 32'hDEAD_BEEF;
    #1 chk("ar_req_out_wr", 64'(bus.req_out), 64'(32'hDEAD_BEEF));
    @(negedge clk);
    bus.l2_ready = 1'b0;
    #1 chk("ar_in_inval", 64'(bus.inv), 64'(4'b1011));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ctl_zero", 64'({bus.l2_en, bus.l2_w, bus.req_ready, bus.inv}), 64'(0));
    chk("ar_addr_zero", 64'({bus.l2_addr, bus.inv_addr}), 64'(0));
    chk("ar_data_zero", 64'({bus.l2_in, bus.req_out}), 64'(0));
    @(negedge clk);
    idle_inputs();
    rst_n           = 1'b1;
    bus.req_en      = 4'b0101;
    bus.req_addr[0] = 16'h0050;
    bus.req_addr[2] = 16'h0456;
    @(negedge clk); #1;
    chk("ar_core0_first_en", 64'(bus.l2_en), 64'(1));
    chk("ar_core0_first", 64'(bus.l2_addr), 64'(16'h0050));

    // ---- Randomized traffic against a transaction-level model
    do_reset();
    pend     = '0;
    seen_rdy = '0;
    m_ptr    = int'(NC) - 1;
    m_owner  = 0;
    m_busy   = 1'b0;
    m_l2done = 1'b0;
    m_fin    = 1'b0;
    m_w      = 1'b0;
    m_acked  = '0;
    m_addr   = '0;
    m_data   = '0;
    m_rdata  = '0;
    lat      = 0;
    for (int c = 0; c < 3000 && n_err < 50; c++) begin
      // L1 side: drop on completion, start new requests, wiggle pending payloads
      for (int i = 0; i < int'(NC); i++) begin
        if (pend[i] && seen_rdy[i]) begin
          pend[i] = 1'b0;
        end else if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i]         = 1'b1;
            bus.req_w[i]    = 1'($urandom_range(0, 1));
            bus.req_addr[i] = {4'(i), 12'($urandom)};
            bus.req_in[i]   = $urandom;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          bus.req_addr[i] = {4'(i), 12'($urandom)};
          bus.req_in[i]   = $urandom;
        end
      end
      bus.req_en = pend;

      // L2 side: random latency per access
      bus.l2_ready = 1'b0;
      if (m_busy && !m_l2done) begin
        if (lat == 0) bus.l2_ready = 1'b1;
        else lat--;
      end
      bus.l2_out = $urandom;
      ack_mask   = NC'($urandom);
      #1;

      own_ix = 2'(m_owner);
      onehot = '0;
      onehot[own_ix] = 1'b1;
      e_l2en = m_busy && !m_l2done;
      e_rdy  = '0;
      e_out  = m_rdata;
      if (e_l2en && bus.l2_ready) begin
        e_out = bus.l2_out;
        if (!m_w) e_rdy = onehot;
      end
      if (m_busy && m_fin) e_rdy = onehot;
      e_inv = (m_busy && m_l2done && !m_fin) ? ~m_acked : '0;

      chk("rnd_l2_en", 64'(bus.l2_en), 64'(e_l2en));
      chk("rnd_l2_w", 64'(bus.l2_w), 64'(e_l2en ? m_w : 1'b0));
      chk("rnd_l2_addr", 64'(bus.l2_addr), 64'(e_l2en ? m_addr : 16'h0));
      chk("rnd_l2_in", 64'(bus.l2_in), 64'(e_l2en ? m_data : 32'h0));
      chk("rnd_req_ready", 64'(bus.req_ready), 64'(e_rdy));
      chk("rnd_req_out", 64'(bus.req_out), 64'(e_out));
      chk("rnd_inv", 64'(bus.inv), 64'(e_inv));
      chk("rnd_inv_addr", 64'(bus.inv_addr), 64'((e_inv != '0) ? m_addr : 16'h0));

      // Advance the model across the coming clock edge
      seen_rdy = bus.req_ready;
      if (!m_busy) begin
        if (pend != '0) begin
          m_owner  = rr_pick(m_ptr, pend);
          own_ix   = 2'(m_owner);
          m_busy   = 1'b1;
          m_l2done = 1'b0;
          m_fin    = 1'b0;
          m_w      = bus.req_w[own_ix];
          m_addr   = bus.req_addr[own_ix];
          m_data   = bus.req_in[own_ix];
          lat      = $urandom_range(0, 3);
        end
      end else if (!m_l2done) begin
        if (bus.l2_ready) begin
          m_rdata = bus.l2_out;
          if (!m_w) begin
            m_busy = 1'b0;
            m_ptr  = m_owner;
          end else begin
            m_l2done = 1'b1;
            m_acked  = onehot;
          end
        end
      end else if (m_fin) begin
        m_busy = 1'b0;
        m_ptr  = m_owner;
      end else begin
        m_acked = m_acked | (e_inv & ack_mask);
        if (&m_acked) m_fin = 1'b1;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
